// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and defaults for the stall/flush controller.
`default_nettype none
package hazard_ctrl_pkg;
  localparam logic [1:0] TUSE_NONE        = 2'd3;
  localparam logic [4:0] REG_ZERO         = 5'd0;
  localparam int         DEF_MULT_CYCLES  = 5;
  localparam int         DEF_DIV_CYCLES   = 10;

  // A source operand stalls when it hits a pending producer whose result
  // arrives later than the consumer needs it.
  function automatic logic src_hazard(input logic [4:0] addr,
                                      input logic [1:0] tuse,
                                      input logic [4:0] wa,
                                      input logic [1:0] tnew);
    src_hazard = (addr != REG_ZERO) && (tuse != TUSE_NONE) &&
                 (addr == wa) && (tuse < tnew);
  endfunction
endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Mult/div busy countdown: loads on unit start, decrements to zero.
`default_nettype none
module hazard_ctrl_md_busy_cnt #(
  parameter int CNT_W       = 4,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start_mult,
  input  logic start_div,
  output logic busy
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (start_div)
      cnt <= CNT_W'(DIV_CYCLES);
    else if (start_mult)
      cnt <= CNT_W'(MULT_CYCLES);
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);
endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: freezes F/D and bubbles E on RAW or HI/LO hazards.
`default_nettype none
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_wa,
  input  logic [1:0] d_tnew,
  input  logic       d_md,
  input  logic       e_start_mult,
  input  logic       e_start_div,
  output logic       f_we,
  output logic       d_we,
  output logic       e_flush,
  output logic       md_busy
);
  logic [4:0] e_wa, m_wa;
  logic [1:0] e_tnew, m_tnew;
  logic       busy;
  logic       stall_rs, stall_rt, stall_md, stall;

  hazard_ctrl_md_busy_cnt #(
    .CNT_W      (CNT_W),
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_cnt (
    .clk       (clk),
    .reset     (reset),
    .start_mult(e_start_mult),
    .start_div (e_start_div),
    .busy      (busy)
  );

  always_comb begin
    stall_rs = src_hazard(d_rs, d_tuse_rs, e_wa, e_tnew) ||
               src_hazard(d_rs, d_tuse_rs, m_wa, m_tnew);
    stall_rt = src_hazard(d_rt, d_tuse_rt, e_wa, e_tnew) ||
               src_hazard(d_rt, d_tuse_rt, m_wa, m_tnew);
    stall_md = d_md && (busy || e_start_mult || e_start_div);
    stall    = stall_rs || stall_rt || stall_md;
  end

  assign f_we    = !stall;
  assign d_we    = !stall;
  assign e_flush = stall;
  assign md_busy = busy;

  // W is not tracked: anything leaving M is already available.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_wa   <= REG_ZERO;
      e_tnew <= 2'd0;
      m_wa   <= REG_ZERO;
      m_tnew <= 2'd0;
    end else begin
      m_wa   <= e_wa;
      m_tnew <= (e_tnew != 2'd0) ? e_tnew - 2'd1 : 2'd0;
      if (stall) begin
        e_wa   <= REG_ZERO;
        e_tnew <= 2'd0;
      end else begin
        e_wa   <= d_wa;
        e_tnew <= d_tnew;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed checks of hazard_ctrl against a ready-time model.
`timescale 1ns/1ps
`default_nettype none
module tb_hazard_ctrl;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] d_rs = '0, d_rt = '0, d_wa = '0;
  logic [1:0] d_tuse_rs = '0, d_tuse_rt = '0, d_tnew = '0;
  logic       d_md = 1'b0, e_start_mult = 1'b0, e_start_div = 1'b0;
  logic       f_we, d_we, e_flush, md_busy;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wa(d_wa), .d_tnew(d_tnew), .d_md(d_md),
    .e_start_mult(e_start_mult), .e_start_div(e_start_div),
    .f_we(f_we), .d_we(d_we), .e_flush(e_flush), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // Model: each producer in E/M is remembered by the absolute cycle its
  // result becomes available; the md unit by the last cycle it is busy.
  int         cyc = 0;
  logic [4:0] me_wa = '0, mm_wa = '0;
  int         me_ready = 0, mm_ready = 0;
  int         busy_until = -1;
  bit         model_valid = 0;

  function automatic bit src_hit(input logic [4:0] a, input logic [1:0] tuse);
    bit h = 0;
    if (a != 0 && tuse != 2'd3) begin
      if (a == me_wa && cyc + int'(tuse) < me_ready) h = 1;
      if (a == mm_wa && cyc + int'(tuse) < mm_ready) h = 1;
    end
    return h;
  endfunction

  function automatic bit model_busy();
    return cyc <= busy_until;
  endfunction

  function automatic bit model_stall();
    return src_hit(d_rs, d_tuse_rs) || src_hit(d_rt, d_tuse_rt) ||
           (d_md && (model_busy() || e_start_mult || e_start_div));
  endfunction

  always @(posedge clk) begin
    bit s;
    s = model_stall();
    if (reset) begin
      me_wa = '0; mm_wa = '0; me_ready = 0; mm_ready = 0; busy_until = -1;
      model_valid = 1;
    end else begin
      mm_wa = me_wa; mm_ready = me_ready;
      if (s) begin
        me_wa = '0; me_ready = 0;
      end else begin
        me_wa = d_wa; me_ready = cyc + 1 + int'(d_tnew);
      end
      if (e_start_div)       busy_until = cyc + DIV_CYCLES;
      else if (e_start_mult) busy_until = cyc + MULT_CYCLES;
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      bit s;
      s = model_stall();
      chk("model_f_we",    f_we,    !s);
      chk("model_d_we",    d_we,    !s);
      chk("model_e_flush", e_flush, s);
      chk("model_md_busy", md_busy, model_busy());
    end
  end

  task automatic step(input logic [4:0] rs, input logic [1:0] trs,
                      input logic [4:0] wa, input logic [1:0] tn,
                      input logic md, input logic sm, input logic sd,
                      input logic rst);
    @(posedge clk); #1;
    d_rs = rs; d_tuse_rs = trs; d_rt = '0; d_tuse_rt = 2'd3;
    d_wa = wa; d_tnew = tn; d_md = md;
    e_start_mult = sm; e_start_div = sd; reset = rst;
  endtask

  task automatic expect_out(input string name, input logic flush, input logic busy);
    @(negedge clk);
    chk({name, "_f_we"},    f_we,    !flush);
    chk({name, "_d_we"},    d_we,    !flush);
    chk({name, "_e_flush"}, e_flush, flush);
    chk({name, "_md_busy"}, md_busy, busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'd3, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset for two cycles, then check reset values.
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("reset", 0, 0);

    // lw $8 then consumer with Tuse=1: one stall cycle.
    step(0, 2'd3, 8, 2, 0, 0, 0, 0);
    step(8, 2'd1, 0, 0, 0, 0, 0, 0); expect_out("lu1_c0", 1, 0);
    step(8, 2'd1, 0, 0, 0, 0, 0, 0); expect_out("lu1_c1", 0, 0);
    idle(3);

    // Tuse=0: two stall cycles.
    step(0, 2'd3, 8, 2, 0, 0, 0, 0);
    step(8, 2'd0, 0, 0, 0, 0, 0, 0); expect_out("lu0_c0", 1, 0);
    step(8, 2'd0, 0, 0, 0, 0, 0, 0); expect_out("lu0_c1", 1, 0);
    step(8, 2'd0, 0, 0, 0, 0, 0, 0); expect_out("lu0_c2", 0, 0);
    idle(3);

    // Destination $0 never creates a hazard.
    step(0, 2'd3, 0, 2, 0, 0, 0, 0);
    step(0, 2'd0, 0, 0, 0, 0, 0, 0); expect_out("zero_c0", 0, 0);
    idle(3);

    // mult in E with mfhi in D: 6 stall cycles, busy for 5.
    step(0, 2'd3, 0, 0, 1, 1, 0, 0); expect_out("mult_start", 1, 0);
    for (int i = 0; i < MULT_CYCLES; i++) begin
      step(0, 2'd3, 0, 0, 1, 0, 0, 0); expect_out("mult_wait", 1, 1);
    end
    step(0, 2'd3, 0, 0, 1, 0, 0, 0); expect_out("mult_release", 0, 0);
    idle(2);

    // div: busy for exactly DIV_CYCLES cycles.
    step(0, 2'd3, 0, 0, 0, 0, 1, 0); expect_out("div_start", 0, 0);
    for (int i = 0; i < DIV_CYCLES; i++) begin
      step(0, 2'd3, 0, 0, 0, 0, 0, 0); expect_out("div_busy", 0, 1);
    end
    step(0, 2'd3, 0, 0, 0, 0, 0, 0); expect_out("div_done", 0, 0);

    // Reset in the middle of a div stall.
    step(0, 2'd3, 0, 0, 1, 0, 1, 0); expect_out("divr_start", 1, 0);
    step(0, 2'd3, 0, 0, 1, 0, 0, 0); expect_out("divr_wait", 1, 1);
    step(0, 2'd3, 0, 0, 1, 0, 0, 1); expect_out("divr_in_rst", 1, 1);
    step(0, 2'd3, 0, 0, 1, 0, 0, 0); expect_out("divr_after", 0, 0);
    idle(2);

    // Randomized traffic with small register addresses to provoke hits.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      d_rs         = 5'($urandom_range(0, 4));
      d_rt         = 5'($urandom_range(0, 4));
      d_tuse_rs    = 2'($urandom_range(0, 3));
      d_tuse_rt    = 2'($urandom_range(0, 3));
      d_wa         = 5'($urandom_range(0, 4));
      d_tnew       = 2'($urandom_range(0, 2));
      d_md         = ($urandom_range(0, 3) == 0);
      e_start_mult = ($urandom_range(0, 15) == 0);
      e_start_div  = ($urandom_range(0, 19) == 0);
      reset        = ($urandom_range(0, 59) == 0);
    end
    @(posedge clk); #1;
    reset = 1'b0; d_md = 0; e_start_mult = 0; e_start_div = 0;
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
